// File: rtl/sticky_shift_if.sv
// sticky_shift_if: request/result handshake bundle for sticky_shift_sequencer.
//   in_valid/in_ready/in_a/in_amt      operand + shift amount request
//   out_valid/out_ready/out_c/out_steps GRS-extended result + SHIFT-cycle count
// master: drives requests and consumes results; slave: the sequencer.
interface sticky_shift_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AMT_WIDTH  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_a;
    logic [AMT_WIDTH-1:0]    in_amt;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH+2:0]   out_c;
    logic [AMT_WIDTH-1:0]    out_steps;

    modport master (
        output in_valid, in_a, in_amt, out_ready,
        input  in_ready, out_valid, out_c, out_steps
    );

    modport slave (
        input  in_valid, in_a, in_amt, out_ready,
        output in_ready, out_valid, out_c, out_steps
    );
endinterface

// File: rtl/sticky_shift_sequencer.sv
// sticky_shift_sequencer: multi-cycle sticky right shift built from a small per-cycle step.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sticky_shift_if.slave: request (in_*) accepted in IDLE, result (out_*) held in HOLD.
// The operand is extended with G/R/S bits, shifted by at most STEP_MAX positions per SHIFT
// cycle while bits falling off the bottom are ORed into bit 0. Shifting stops as soon as the
// remaining amount is exhausted or no non-sticky bit is left to move.
module sticky_shift_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned STEP_MAX   = 3,
    parameter int unsigned AMT_WIDTH  = 8
) (
    input logic           clk,
    input logic           rst,
    sticky_shift_if.slave bus
);
    localparam int unsigned W = DATA_WIDTH + 3;
    localparam logic [AMT_WIDTH-1:0] AMT_CLAMP = AMT_WIDTH'(W);
    localparam logic [AMT_WIDTH-1:0] STEP_LIM  = AMT_WIDTH'(STEP_MAX);
    localparam logic [W-1:0]         ONES      = '1;

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e               state_q, state_d;
    logic [W-1:0]         w_q, w_d;
    logic [AMT_WIDTH-1:0] rem_q, rem_d;
    logic [AMT_WIDTH-1:0] steps_q, steps_d;

    logic [AMT_WIDTH-1:0] s;
    logic [AMT_WIDTH-1:0] rem_next;
    logic [W-1:0]         sticky_mask;
    logic [W-1:0]         w_step;

    // One step of s positions: upper field shifts, bit 0 absorbs w[s:0].
    always_comb begin
        s           = (rem_q < STEP_LIM) ? rem_q : STEP_LIM;
        sticky_mask = ~((ONES << 1) << s);
        w_step      = {w_q[W-1:1] >> s, |(w_q & sticky_mask)};
        rem_next    = rem_q - s;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        rem_d   = rem_q;
        steps_d = steps_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    w_d     = {bus.in_a, 3'b000};
                    rem_d   = (bus.in_amt > AMT_CLAMP) ? AMT_CLAMP : bus.in_amt;
                    steps_d = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                w_d     = w_step;
                rem_d   = rem_next;
                steps_d = steps_q + AMT_WIDTH'(1);
                // Once only the sticky bit can be non-zero, further steps cannot change w.
                if (rem_next == '0 || w_step[W-1:1] == '0) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            w_q     <= '0;
            rem_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            rem_q   <= rem_d;
            steps_q <= steps_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_c     = w_q;
    assign bus.out_steps = steps_q;
endmodule

// File: tb/tb_sticky_shift_sequencer.sv
module tb_sticky_shift_sequencer;
    localparam int unsigned N    = 16;
    localparam int unsigned W    = N + 3;
    localparam int unsigned AW   = 8;
    localparam int unsigned STEP = 3;

    typedef struct {
        logic [W-1:0]  c;
        logic [AW-1:0] steps;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    sticky_shift_if #(.DATA_WIDTH(N), .AMT_WIDTH(AW)) bus ();

    sticky_shift_sequencer #(.DATA_WIDTH(N), .STEP_MAX(STEP), .AMT_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One-shot reference: shift {a,000} right by k and OR x[k:0] into bit 0.
    function automatic logic [W-1:0] ref_c(input logic [N-1:0] a, input logic [AW-1:0] amt);
        logic [W-1:0] x;
        logic [W-1:0] r;
        int           k;
        x = {a, 3'b000};
        k = (int'(amt) > int'(W)) ? int'(W) : int'(amt);
        r = x >> k;
        r[0] = 1'b0;
        for (int i = 0; i <= k && i < int'(W); i++) r[0] = r[0] | x[i];
        return r;
    endfunction

    // Cycles needed: ceil(min(k, msb)/STEP), at least one.
    function automatic logic [AW-1:0] ref_steps(input logic [N-1:0] a, input logic [AW-1:0] amt);
        logic [W-1:0] x;
        int           k;
        int           p;
        int           m;
        int           n;
        x = {a, 3'b000};
        k = (int'(amt) > int'(W)) ? int'(W) : int'(amt);
        p = 0;
        for (int i = 0; i < int'(W); i++) if (x[i]) p = i;
        m = (k < p) ? k : p;
        n = (m + int'(STEP) - 1) / int'(STEP);
        if (n < 1) n = 1;
        return AW'(n);
    endfunction

    // Present a request until accepted; push the expected result on acceptance.
    task automatic send(input logic [N-1:0] a, input logic [AW-1:0] amt,
                        input logic [W-1:0] ec, input logic [AW-1:0] es, output bit ok);
        exp_t e;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_amt   = amt;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0;
        end else begin
            @(posedge clk); #1;
            e.c     = ec;
            e.steps = es;
            sb.push_back(e);
            ok = 1'b1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid, stall, then complete the output handshake.
    task automatic recv(input int stall, output logic [W-1:0] c, output logic [AW-1:0] st,
                        output int lat, output bit ok);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = bus.out_valid;
        c  = bus.out_c;
        st = bus.out_steps;
        if (ok) begin
            bus.out_ready = 1'b0;
            repeat (stall) begin
                @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_c !== '0) begin n_err++;
            $display("FAIL reset_out_c: got %h want 0", bus.out_c); end
        n_cmp++; if (bus.out_steps !== '0) begin n_err++;
            $display("FAIL reset_out_steps: got %h want 0", bus.out_steps); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Directed case: request, fixed expectation, optional latency check.
    task automatic test_directed(input string name, input logic [N-1:0] a,
                                 input logic [AW-1:0] amt, input logic [W-1:0] ec,
                                 input logic [AW-1:0] es, input int exp_lat);
        bit            ok;
        logic [W-1:0]  c;
        logic [AW-1:0] st;
        int            lat;
        exp_t          e;
        send(a, amt, ec, es, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_accept: got timeout want accept", name); end
        recv(0, c, st, lat, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_valid: got timeout want out_valid", name); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++; if (c !== e.c) begin n_err++;
                $display("FAIL %s_c: got %h want %h", name, c, e.c); end
            n_cmp++; if (st !== e.steps) begin n_err++;
                $display("FAIL %s_steps: got %0d want %0d", name, st, e.steps); end
        end
        if (exp_lat > 0) begin
            n_cmp++; if (lat != exp_lat) begin n_err++;
                $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
        end
    endtask

    task automatic test_basic;
        test_directed("zero_amt", 16'h8001, 8'd0, 19'h40008, 8'd1, 1);
        test_directed("amt5", 16'h8001, 8'd5, 19'h02001, 8'd2, 2);
        test_directed("amt17", 16'hFFFF, 8'd17, 19'h00003, 8'd6, 6);
        test_directed("amt18", 16'hFFFF, 8'd18, 19'h00001, 8'd6, 6);
    endtask

    task automatic test_early_term;
        test_directed("early_one", 16'h0001, 8'd40, 19'h00001, 8'd1, 1);
        test_directed("early_zero", 16'h0000, 8'd200, 19'h00000, 8'd1, 1);
    endtask

    task automatic test_backpressure;
        bit            ok;
        logic [W-1:0]  c0;
        logic [AW-1:0] s0;
        logic [W-1:0]  c;
        logic [AW-1:0] st;
        int            lat;
        exp_t          e;
        send(16'h8001, 8'd5, 19'h02001, 8'd2, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_accept: got timeout want accept"); end
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++;
            $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'hFFFF;
        bus.in_amt    = 8'd17;
        c0 = bus.out_c;
        s0 = bus.out_steps;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++; if (c0 !== e.c) begin n_err++;
                $display("FAIL bp_c: got %h want %h", c0, e.c); end
            n_cmp++; if (s0 !== e.steps) begin n_err++;
                $display("FAIL bp_steps: got %0d want %0d", s0, e.steps); end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_c !== c0) begin n_err++;
                $display("FAIL bp_stable_c: got %h want %h", bus.out_c, c0); end
            n_cmp++; if (bus.out_steps !== s0) begin n_err++;
                $display("FAIL bp_stable_steps: got %0d want %0d", bus.out_steps, s0); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++;
                $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++;
                $display("FAIL bp_hold_valid: got %b want 1", bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        // Output handshake only: back in IDLE, pending request not yet taken.
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_release: got ready=%b valid=%b want ready=1 valid=0",
                     bus.in_ready, bus.out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++;
            $display("FAIL bp_next_accept: got in_ready=%b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        e.c     = 19'h00003;
        e.steps = 8'd6;
        sb.push_back(e);
        recv(0, c, st, lat, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp2_valid: got timeout want out_valid"); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++; if (c !== e.c) begin n_err++;
                $display("FAIL bp2_c: got %h want %h", c, e.c); end
            n_cmp++; if (st !== e.steps) begin n_err++;
                $display("FAIL bp2_steps: got %0d want %0d", st, e.steps); end
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        send(16'hFFFF, 8'd17, 19'h00003, 8'd6, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ar_accept: got timeout want accept"); end
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL ar_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL ar_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_c !== '0) begin n_err++;
            $display("FAIL ar_out_c: got %h want 0", bus.out_c); end
        n_cmp++; if (bus.out_steps !== '0) begin n_err++;
            $display("FAIL ar_out_steps: got %0d want 0", bus.out_steps); end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed("ar_after", 16'h8001, 8'd5, 19'h02001, 8'd2, 2);
    endtask

    task automatic test_random;
        bit            ok;
        logic [N-1:0]  a;
        logic [AW-1:0] amt;
        logic [W-1:0]  c;
        logic [AW-1:0] st;
        int            lat;
        int            stall;
        exp_t          e;
        for (int t = 0; t < 10000; t++) begin
            a = N'($urandom);
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 15);
            amt = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 21));
            stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            send(a, amt, ref_c(a, amt), ref_steps(a, amt), ok);
            if (!ok) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_accept: got timeout want accept (a=%h amt=%0d)", a, amt);
                break;
            end
            recv(stall, c, st, lat, ok);
            if (!ok) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_valid: got timeout want out_valid (a=%h amt=%0d)", a, amt);
                break;
            end
            e = sb.pop_front();
            n_cmp++; if (c !== e.c) begin n_err++;
                $display("FAIL rnd_c: a=%h amt=%0d got %h want %h", a, amt, c, e.c); end
            n_cmp++; if (st !== e.steps) begin n_err++;
                $display("FAIL rnd_steps: a=%h amt=%0d got %0d want %0d", a, amt, st, e.steps); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_term();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
